// File: rtl/rv_mem_pkg.sv
// Shared encodings for the MEM stage: funct3 codes, writeback exception codes, FSM states.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package rv_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] EXC_NONE     = 2'b00;
    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_TIMEOUT  = 2'b10;
    localparam logic [1:0] EXC_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    function automatic logic f3_illegal(input logic is_ld, input logic [2:0] f3);
        if (is_ld)
            return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        return !((f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW));
    endfunction

    // funct3[1:0] carries the access size for both loads and stores.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a_lo);
        return ((f3[1:0] == 2'b01) && a_lo[0]) || ((f3[1:0] == 2'b10) && (a_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Extracts and sign/zero-extends the addressed byte/halfword/word from a load word.
// Latency: combinational.
// Backpressure: none.
module mem_load_align
    import rv_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  a_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;
    assign shifted = rdata >> {a_lo, 3'b000};

    always_comb begin
        data = '0;
        case (funct3)
            F3_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LW:   data = shifted;
            F3_LBU:  data = {24'h0, shifted[7:0]};
            F3_LHU:  data = {16'h0, shifted[15:0]};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues aligned load/store on the dmem port, registers the MEM/WB result.
// Latency: 1 cycle non-memory, >=2 cycles store, >=3 cycles load (abandoned after TIMEOUT_CYCLES).
// Backpressure: mem_stall holds EX/MEM while a transaction is outstanding; dmem_req held until dmem_ready.
module mem_access_stage
    import rv_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_out,
    input  logic [31:0] ex_rs2_data,
    input  logic        ex_mem_rd,
    input  logic        ex_mem_wr,
    input  logic [2:0]  ex_funct3,
    input  logic [4:0]  ex_rd_addr,
    input  logic        ex_reg_wr,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd_addr,
    output logic        wb_reg_wr,
    output logic [1:0]  wb_exc
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  alo_q, alo_d;
    logic [4:0]  rd_q, rd_d;
    logic        reg_wr_q, reg_wr_d;
    logic        dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
    logic [31:0] dmem_addr_q, dmem_addr_d, dmem_wdata_q, dmem_wdata_d;
    logic [3:0]  dmem_be_q, dmem_be_d;
    logic        wb_valid_q, wb_valid_d, wb_reg_wr_q, wb_reg_wr_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_rd_addr_q, wb_rd_addr_d;
    logic [1:0]  wb_exc_q, wb_exc_d;
    logic [31:0] load_val;
    logic        ack;

    mem_load_align u_align (
        .rdata  (dmem_rdata),
        .a_lo   (alo_q),
        .funct3 (f3_q),
        .data   (load_val)
    );

    assign ack = ((state_q == ST_REQ) && dmem_ready) || ((state_q == ST_RESP) && dmem_rvalid);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        f3_d         = f3_q;
        alo_d        = alo_q;
        rd_d         = rd_q;
        reg_wr_d     = reg_wr_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        dmem_be_d    = dmem_be_q;
        wb_valid_d   = 1'b0;
        wb_data_d    = wb_data_q;
        wb_rd_addr_d = wb_rd_addr_q;
        wb_reg_wr_d  = wb_reg_wr_q;
        wb_exc_d     = wb_exc_q;

        case (state_q)
            ST_IDLE: begin
                if (ex_valid) begin
                    wb_data_d    = ex_alu_out;
                    wb_rd_addr_d = ex_rd_addr;
                    if (!ex_mem_rd && !ex_mem_wr) begin
                        wb_valid_d  = 1'b1;
                        wb_reg_wr_d = ex_reg_wr;
                        wb_exc_d    = EXC_NONE;
                    end else if (f3_illegal(ex_mem_rd, ex_funct3)) begin
                        wb_valid_d  = 1'b1;
                        wb_reg_wr_d = 1'b0;
                        wb_exc_d    = EXC_ILLEGAL;
                    end else if (misaligned(ex_funct3, ex_alu_out[1:0])) begin
                        wb_valid_d  = 1'b1;
                        wb_reg_wr_d = 1'b0;
                        wb_exc_d    = EXC_MISALIGN;
                    end else begin
                        f3_d        = ex_funct3;
                        alo_d       = ex_alu_out[1:0];
                        rd_d        = ex_rd_addr;
                        reg_wr_d    = ex_reg_wr;
                        dmem_req_d  = 1'b1;
                        dmem_we_d   = ex_mem_wr;
                        dmem_addr_d = {ex_alu_out[31:2], 2'b00};
                        cnt_d       = '0;
                        state_d     = ST_REQ;
                        if (!ex_mem_wr) begin
                            dmem_be_d    = 4'b1111;
                            dmem_wdata_d = '0;
                        end else if (ex_funct3 == F3_SB) begin
                            dmem_be_d    = 4'b0001 << ex_alu_out[1:0];
                            dmem_wdata_d = {4{ex_rs2_data[7:0]}};
                        end else if (ex_funct3 == F3_SH) begin
                            dmem_be_d    = 4'b0011 << ex_alu_out[1:0];
                            dmem_wdata_d = {2{ex_rs2_data[15:0]}};
                        end else begin
                            dmem_be_d    = 4'b1111;
                            dmem_wdata_d = ex_rs2_data;
                        end
                    end
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + 8'd1;
                if (dmem_ready) begin
                    dmem_req_d = 1'b0;
                    if (dmem_we_q) begin
                        wb_valid_d   = 1'b1;
                        wb_data_d    = '0;
                        wb_rd_addr_d = rd_q;
                        wb_reg_wr_d  = 1'b0;
                        wb_exc_d     = EXC_NONE;
                        state_d      = ST_IDLE;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                cnt_d = cnt_q + 8'd1;
                if (dmem_rvalid) begin
                    wb_valid_d   = 1'b1;
                    wb_data_d    = load_val;
                    wb_rd_addr_d = rd_q;
                    wb_reg_wr_d  = reg_wr_q;
                    wb_exc_d     = EXC_NONE;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A handshake landing in the final allowed cycle still completes normally.
        if ((state_q != ST_IDLE) && !ack && (cnt_q >= TO_LAST)) begin
            wb_valid_d   = 1'b1;
            wb_data_d    = '0;
            wb_rd_addr_d = rd_q;
            wb_reg_wr_d  = 1'b0;
            wb_exc_d     = EXC_TIMEOUT;
            dmem_req_d   = 1'b0;
            state_d      = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            f3_q         <= '0;
            alo_q        <= '0;
            rd_q         <= '0;
            reg_wr_q     <= 1'b0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            dmem_be_q    <= '0;
            wb_valid_q   <= 1'b0;
            wb_data_q    <= '0;
            wb_rd_addr_q <= '0;
            wb_reg_wr_q  <= 1'b0;
            wb_exc_q     <= EXC_NONE;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            f3_q         <= f3_d;
            alo_q        <= alo_d;
            rd_q         <= rd_d;
            reg_wr_q     <= reg_wr_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            dmem_be_q    <= dmem_be_d;
            wb_valid_q   <= wb_valid_d;
            wb_data_q    <= wb_data_d;
            wb_rd_addr_q <= wb_rd_addr_d;
            wb_reg_wr_q  <= wb_reg_wr_d;
            wb_exc_q     <= wb_exc_d;
        end
    end

    assign mem_stall  = (state_q != ST_IDLE);
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign dmem_be    = dmem_be_q;
    assign wb_valid   = wb_valid_q;
    assign wb_data    = wb_data_q;
    assign wb_rd_addr = wb_rd_addr_q;
    assign wb_reg_wr  = wb_reg_wr_q;
    assign wb_exc     = wb_exc_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: vector table + scoreboard on the writeback port, plus corner sequences.
// Latency: n/a.
// Backpressure: bench plays the dmem responder with programmable ready delay.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_alu_out = '0;
    logic [31:0] ex_rs2_data = '0;
    logic        ex_mem_rd = 1'b0;
    logic        ex_mem_wr = 1'b0;
    logic [2:0]  ex_funct3 = '0;
    logic [4:0]  ex_rd_addr = '0;
    logic        ex_reg_wr = 1'b0;
    logic        mem_stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        wb_valid, wb_reg_wr;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd_addr;
    logic [1:0]  wb_exc;

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ex_valid    (ex_valid),
        .ex_alu_out  (ex_alu_out),
        .ex_rs2_data (ex_rs2_data),
        .ex_mem_rd   (ex_mem_rd),
        .ex_mem_wr   (ex_mem_wr),
        .ex_funct3   (ex_funct3),
        .ex_rd_addr  (ex_rd_addr),
        .ex_reg_wr   (ex_reg_wr),
        .mem_stall   (mem_stall),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_be     (dmem_be),
        .dmem_ready  (dmem_ready),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .wb_valid    (wb_valid),
        .wb_data     (wb_data),
        .wb_rd_addr  (wb_rd_addr),
        .wb_reg_wr   (wb_reg_wr),
        .wb_exc      (wb_exc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld, st;
        logic [2:0]  f3;
        logic [31:0] a, rs2;
        logic [4:0]  rd;
        logic        reg_wr;
        int          dly;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata, e_data;
        logic        e_reg_wr;
        logic [1:0]  e_exc;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        reg_wr;
        logic [1:0]  exc;
        logic        chk_data;
    } sb_item_t;

    sb_item_t sb[$];
    sb_item_t it_m;
    vec_t     vecs[16];
    int       n_cmp = 0;
    int       n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && wb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_wb_valid", {31'h0, wb_valid}, 32'h0);
            end else begin
                it_m = sb.pop_front();
                if (it_m.chk_data) check("wb_data", wb_data, it_m.data);
                check("wb_rd_addr", {27'h0, wb_rd_addr}, {27'h0, it_m.rd});
                check("wb_reg_wr", {31'h0, wb_reg_wr}, {31'h0, it_m.reg_wr});
                check("wb_exc", {30'h0, wb_exc}, {30'h0, it_m.exc});
            end
        end
    end

    task automatic drive(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rs2, input logic [4:0] rd, input logic reg_wr);
        ex_valid    = 1'b1;
        ex_mem_rd   = ld;
        ex_mem_wr   = st;
        ex_funct3   = f3;
        ex_alu_out  = a;
        ex_rs2_data = rs2;
        ex_rd_addr  = rd;
        ex_reg_wr   = reg_wr;
    endtask

    task automatic idle_ex();
        ex_valid  = 1'b0;
        ex_mem_rd = 1'b0;
        ex_mem_wr = 1'b0;
    endtask

    task automatic push(input logic [31:0] d, input logic [4:0] rd, input logic rw,
                        input logic [1:0] exc, input logic chk);
        sb_item_t it;
        it.data = d; it.rd = rd; it.reg_wr = rw; it.exc = exc; it.chk_data = chk;
        sb.push_back(it);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            check("wb_wait_expired", sb.size(), 0);
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic apply_vec(input vec_t v);
        drive(v.ld, v.st, v.f3, v.a, v.rs2, v.rd, v.reg_wr);
        push(v.e_data, v.rd, v.e_reg_wr, v.e_exc, (v.e_exc == 2'b00) && !v.st);
        @(posedge clk); #1;
        idle_ex();
        @(negedge clk);
        if (v.e_req) begin
            check("dmem_req", {31'h0, dmem_req}, 32'h1);
            check("dmem_we", {31'h0, dmem_we}, {31'h0, v.st});
            check("dmem_addr", dmem_addr, v.e_addr);
            check("dmem_be", {28'h0, dmem_be}, {28'h0, v.e_be});
            check("dmem_wdata", dmem_wdata, v.e_wdata);
            check("stall_busy", {31'h0, mem_stall}, 32'h1);
            for (int i = 0; i < v.dly; i++) begin
                @(posedge clk); #1;
                check("req_held", {31'h0, dmem_req}, 32'h1);
                check("addr_held", dmem_addr, v.e_addr);
            end
            dmem_ready = 1'b1;
            @(posedge clk); #1;
            dmem_ready = 1'b0;
            check("req_drop", {31'h0, dmem_req}, 32'h0);
            check("stall_after_ready", {31'h0, mem_stall}, {31'h0, v.ld});
            if (v.ld) begin
                dmem_rvalid = 1'b1;
                dmem_rdata  = v.rdata;
                @(posedge clk); #1;
                dmem_rvalid = 1'b0;
                check("stall_after_rvalid", {31'h0, mem_stall}, 32'h0);
            end
        end else begin
            check("no_req", {31'h0, dmem_req}, 32'h0);
            check("no_stall", {31'h0, mem_stall}, 32'h0);
        end
        drain();
    endtask

    initial begin
        //           ld st f3    a             rs2           rd     rw dly rdata         req addr          be       wdata         data          erw exc
        vecs[0]  = '{0, 0, 3'd0, 32'h0000_0010, 32'h0,        5'd5,  1, 0, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0000_0010, 1, 2'b00};
        vecs[1]  = '{0, 0, 3'd0, 32'hDEAD_BEEF, 32'h0,        5'd0,  0, 0, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'hDEAD_BEEF, 0, 2'b00};
        vecs[2]  = '{0, 1, 3'd0, 32'h0000_0103, 32'h1234_56AB, 5'd7,  0, 2, 32'h0,        1, 32'h0000_0100, 4'b1000, 32'hABAB_ABAB, 32'h0,        0, 2'b00};
        vecs[3]  = '{0, 1, 3'd1, 32'h0000_0202, 32'hCAFE_BEEF, 5'd8,  0, 0, 32'h0,        1, 32'h0000_0200, 4'b1100, 32'hBEEF_BEEF, 32'h0,        0, 2'b00};
        vecs[4]  = '{0, 1, 3'd2, 32'h0000_0300, 32'h1122_3344, 5'd9,  0, 1, 32'h0,        1, 32'h0000_0300, 4'b1111, 32'h1122_3344, 32'h0,        0, 2'b00};
        vecs[5]  = '{1, 0, 3'd1, 32'h0000_0202, 32'h0,        5'd10, 1, 1, 32'h8001_7FFF, 1, 32'h0000_0200, 4'b1111, 32'h0,        32'hFFFF_8001, 1, 2'b00};
        vecs[6]  = '{1, 0, 3'd5, 32'h0000_0202, 32'h0,        5'd11, 1, 0, 32'h8001_7FFF, 1, 32'h0000_0200, 4'b1111, 32'h0,        32'h0000_8001, 1, 2'b00};
        vecs[7]  = '{1, 0, 3'd0, 32'h0000_0101, 32'h0,        5'd12, 1, 0, 32'h1234_80FF, 1, 32'h0000_0100, 4'b1111, 32'h0,        32'hFFFF_FF80, 1, 2'b00};
        vecs[8]  = '{1, 0, 3'd4, 32'h0000_0103, 32'h0,        5'd13, 1, 2, 32'hA500_0000, 1, 32'h0000_0100, 4'b1111, 32'h0,        32'h0000_00A5, 1, 2'b00};
        vecs[9]  = '{1, 0, 3'd2, 32'h0000_0400, 32'h0,        5'd14, 1, 1, 32'hDEAD_BEEF, 1, 32'h0000_0400, 4'b1111, 32'h0,        32'hDEAD_BEEF, 1, 2'b00};
        vecs[10] = '{1, 0, 3'd2, 32'h0000_0006, 32'h0,        5'd15, 1, 0, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 2'b01};
        vecs[11] = '{1, 0, 3'd1, 32'h0000_0001, 32'h0,        5'd16, 1, 0, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 2'b01};
        vecs[12] = '{0, 1, 3'd2, 32'h0000_0002, 32'h55,       5'd17, 0, 0, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 2'b01};
        vecs[13] = '{1, 0, 3'd3, 32'h0000_0000, 32'h0,        5'd18, 1, 0, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 2'b11};
        vecs[14] = '{0, 1, 3'd4, 32'h0000_0000, 32'h0,        5'd19, 0, 0, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 2'b11};
        vecs[15] = '{1, 0, 3'd7, 32'h0000_0003, 32'h0,        5'd20, 1, 0, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 2'b11};

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
        check("rst_dmem_req", {31'h0, dmem_req}, 32'h0);
        check("rst_mem_stall", {31'h0, mem_stall}, 32'h0);
        check("rst_wb_data", wb_data, 32'h0);
        check("rst_dmem_be", {28'h0, dmem_be}, 32'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) apply_vec(vecs[i]);

        // Back-to-back non-memory ops: one result per cycle, never stalling.
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 3'd0, 32'h100 + i, 32'h0, 5'(21 + i), 1);
            push(32'h100 + i, 5'(21 + i), 1, 2'b00, 1);
            @(posedge clk); #1;
            check("tp_stall", {31'h0, mem_stall}, 32'h0);
        end
        idle_ex();
        drain();

        // Misaligned LW is retired without a request; the next op enters right behind it.
        drive(1, 0, 3'd2, 32'h6, 32'h0, 5'd3, 1);
        push(32'h0, 5'd3, 0, 2'b01, 0);
        @(posedge clk); #1;
        drive(0, 0, 3'd0, 32'h77, 32'h0, 5'd4, 1);
        push(32'h77, 5'd4, 1, 2'b00, 1);
        check("mis_no_req", {31'h0, dmem_req}, 32'h0);
        check("mis_no_stall", {31'h0, mem_stall}, 32'h0);
        @(posedge clk); #1;
        idle_ex();
        check("mis_next_no_req", {31'h0, dmem_req}, 32'h0);
        drain();

        // Bus timeout with dmem_ready never asserted.
        drive(1, 0, 3'd2, 32'h500, 32'h0, 5'd6, 1);
        push(32'h0, 5'd6, 0, 2'b10, 0);
        @(posedge clk); #1;
        idle_ex();
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("to_wait_wb", {31'h0, wb_valid}, 32'h0);
            check("to_wait_req", {31'h0, dmem_req}, 32'h1);
        end
        @(negedge clk);
        check("to_wb_valid", {31'h0, wb_valid}, 32'h1);
        check("to_req_low", {31'h0, dmem_req}, 32'h0);
        check("to_idle", {31'h0, mem_stall}, 32'h0);
        @(posedge clk); #1;
        drain();

        // Reset while waiting in RESP; a stale rvalid afterwards must not retire anything.
        drive(1, 0, 3'd1, 32'h202, 32'h0, 5'd9, 1);
        @(posedge clk); #1;
        idle_ex();
        dmem_ready = 1'b1;
        @(posedge clk); #1;
        dmem_ready = 1'b0;
        check("resp_stall", {31'h0, mem_stall}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_wb_valid", {31'h0, wb_valid}, 32'h0);
        check("arst_dmem_req", {31'h0, dmem_req}, 32'h0);
        check("arst_stall", {31'h0, mem_stall}, 32'h0);
        check("arst_be", {28'h0, dmem_be}, 32'h0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h8001_7FFF;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stale_no_wb", {31'h0, wb_valid}, 32'h0);
        end
        if (sb.size() != 0) check("sb_leftover", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
